// File: rtl/rf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rf_sequencer
// Brief    : Initiator-side controller for an 8x16 register file. Accepts one
//            register-to-register instruction (MOV-imm, ADD, AND, MVN), reads
//            the operands through the read port, computes the result and
//            stores it through the write port, then pulses o_done.
// Options  : RF_SEQUENCER_SHIFTER_EN - builds the B-operand shifter
//            (none / LSL1 / LSR1 / ASR1) selected by the latched shift field.
// Revision : 1.0 - initial release
// ============================================================================
module rf_sequencer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [2:0]  i_rd,
  input  logic [2:0]  i_rn,
  input  logic [2:0]  i_rm,
  input  logic [7:0]  i_imm,
  input  logic [1:0]  i_shift,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_result,
  output logic [2:0]  o_status,
  output logic [2:0]  o_rf_readnum,
  input  logic [15:0] i_rf_data_out,
  output logic [2:0]  o_rf_writenum,
  output logic        o_rf_write,
  output logic [15:0] o_rf_data_in
);

  localparam logic [1:0] c_OP_MOV = 2'b00;
  localparam logic [1:0] c_OP_ADD = 2'b01;
  localparam logic [1:0] c_OP_AND = 2'b10;
  localparam logic [1:0] c_OP_MVN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Latched instruction fields and captured operands
  logic [1:0]  r_op;
  logic [2:0]  r_rd;
  logic [2:0]  r_rm;
  logic [7:0]  r_imm;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_result;
  logic [2:0]  r_status;
  logic [2:0]  r_readnum;
  logic [2:0]  r_writenum;
  logic [15:0] r_data_in;
  logic        r_done;

  logic [15:0] w_bs;
  logic [15:0] w_sum;
  logic [15:0] w_c;
  logic        w_v;
  logic [2:0]  w_flags;

`ifdef RF_SEQUENCER_SHIFTER_EN
  logic [1:0]  r_shift;

  // Latch the shift select together with the rest of the instruction
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= 2'b00;
    end else if (r_state == S_IDLE && i_start) begin
      r_shift <= i_shift;
    end
  end

  // B-operand shifter: none, LSL1, LSR1 (zero fill), ASR1
  always_comb begin
    w_bs = r_b;
    case (r_shift)
      2'b01:   w_bs = {r_b[14:0], 1'b0};
      2'b10:   w_bs = {1'b0, r_b[15:1]};
      2'b11:   w_bs = {r_b[15], r_b[15:1]};
      default: w_bs = r_b;
    endcase
  end
`else
  // Without the shifter the shift field has no consumer
  logic w_unused_shift;
  assign w_unused_shift = ^i_shift;
  assign w_bs           = r_b;
`endif

  assign w_sum = r_a + w_bs;

  // ALU: result and signed-overflow flag for the latched opcode
  always_comb begin
    w_c = 16'h0000;
    w_v = 1'b0;
    case (r_op)
      c_OP_MOV: w_c = {{8{r_imm[7]}}, r_imm};
      c_OP_ADD: begin
        w_c = w_sum;
        w_v = (r_a[15] == w_bs[15]) && (w_sum[15] != r_a[15]);
      end
      c_OP_AND: w_c = r_a & w_bs;
      c_OP_MVN: w_c = ~w_bs;
      default:  w_c = 16'h0000;
    endcase
  end

  assign w_flags = {(w_c == 16'h0000), w_c[15], w_v};

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; MOV skips both reads, MVN skips the A read
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          case (i_op)
            c_OP_MOV: w_next = S_EXEC;
            c_OP_MVN: w_next = S_READ_B;
            default:  w_next = S_READ_A;
          endcase
        end
      end
      S_READ_A: w_next = S_READ_B;
      S_READ_B: w_next = S_EXEC;
      S_EXEC:   w_next = S_WRITE;
      S_WRITE:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: latch instruction, steer read address one state ahead, capture
  // operands, and register the result, flags and write-port values
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_op       <= 2'b00;
      r_rd       <= 3'd0;
      r_rm       <= 3'd0;
      r_imm      <= 8'h00;
      r_a        <= 16'h0000;
      r_b        <= 16'h0000;
      r_result   <= 16'h0000;
      r_status   <= 3'b000;
      r_readnum  <= 3'd0;
      r_writenum <= 3'd0;
      r_data_in  <= 16'h0000;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_WRITE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op  <= i_op;
            r_rd  <= i_rd;
            r_rm  <= i_rm;
            r_imm <= i_imm;
            if (i_op == c_OP_ADD || i_op == c_OP_AND) begin
              r_readnum <= i_rn;
            end else if (i_op == c_OP_MVN) begin
              r_readnum <= i_rm;
            end
          end
        end
        S_READ_A: begin
          r_a       <= i_rf_data_out;
          r_readnum <= r_rm;
        end
        S_READ_B: begin
          r_b <= i_rf_data_out;
        end
        S_EXEC: begin
          r_result   <= w_c;
          r_status   <= w_flags;
          r_writenum <= r_rd;
          r_data_in  <= w_c;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_result      = r_result;
  assign o_status      = r_status;
  assign o_rf_readnum  = r_readnum;
  assign o_rf_writenum = r_writenum;
  assign o_rf_write    = (r_state == S_WRITE);
  assign o_rf_data_in  = r_data_in;

endmodule
`default_nettype wire

// File: doc/rf_sequencer.md
# rf_sequencer

Initiator-side controller for the 8×16 register file: it accepts one register-to-register instruction, drives the register file's read port to fetch operands, and computes the result in a small ALU. It then drives the write port to store the result and reports completion and status flags. It sits between the instruction decode logic and the register file. It owns `readnum`, `writenum`, `write` and `data_in`, and consumes `data_out`.

## Interface
- No parameters. Register count is fixed at 8, data width at 16.
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 MOV-imm, 01 ADD, 10 AND, 11 MVN
- `rd`, `rn`, `rm`  in  3 each  destination, operand-A and operand-B register numbers
- `imm`  in  8  immediate for MOV, sign-extended to 16
- `shift`  in  2  B-operand shift select; used only with SHIFTER_EN
- `busy`  out  1  high while an instruction is in flight
- `done`  out  1  one-cycle completion pulse
- `result`  out  16  last computed value
- `status`  out  3  {Z, N, V} of the last completed instruction
- `rf_readnum`  out  3  to register file `readnum`
- `rf_data_out`  in  16  from register file `data_out` (combinational read)
- `rf_writenum`  out  3  to register file `writenum`
- `rf_write`  out  1  to register file `write`
- `rf_data_in`  out  16  to register file `data_in`

## Operation
- States: IDLE, READ_A, READ_B, EXEC, WRITE.
- IDLE with `start`=1:
  - Latch `op`, `rd`, `rn`, `rm`, `imm` and `shift` into internal fields. Later input changes do not affect the instruction.
  - Next state: MOV goes to EXEC; MVN goes to READ_B; ADD and AND go to READ_A.
- READ_A: `rf_readnum`=latched `rn`; capture A=`rf_data_out`; go to READ_B.
- READ_B: `rf_readnum`=latched `rm`; capture B=`rf_data_out`; go to EXEC.
- EXEC: compute C and capture C into `result`; update `status`; go to WRITE.
  - MOV: C=sext(imm).
  - ADD: C=A+B', mod 2^16.
  - AND: C=A&B'.
  - MVN: C=~B'.
  - B' is B, or shifted B when SHIFTER_EN is defined.
- WRITE: `rf_write`=1, `rf_writenum`=latched `rd`, `rf_data_in`=C; go to IDLE and pulse `done`.
- Flags:
  - Z=(C==0).
  - N=C[15].
  - V=ADD signed overflow (A[15]==B'[15] and C[15]!=A[15]); V=0 for all other ops.
- Outside WRITE: `rf_write`=0.
- Outside the read states: `rf_readnum` holds its last value.
- `rf_writenum` and `rf_data_in` hold their last values.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored and is not queued.
- rd==rn or rd==rm: operands are read before the write, so the old value is used, e.g. R1←R1+R1 doubles R1.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - `busy`, `done`, `rf_write` = 0.
  - `rf_readnum`, `rf_writenum` = 0.
  - `rf_data_in`, `result` = 0; `status`=000.
  - No register-file write occurs on any edge while `reset`=1.
- Latency, with start sampled at edge E0:
  - ADD/AND: register-file write at E4; `done` high in the cycle after E4.
  - MVN: write at E3.
  - MOV: write at E2.
- `done` is registered, high for exactly one cycle, and coincides with IDLE. `start` in that cycle is accepted, so ADD/AND throughput is one instruction per 5 cycles.
- `result` and `status` update at the edge leaving EXEC and hold until the next EXEC.
- Reset asserted mid-instruction aborts it: no write, no `done`, and `result`/`status` clear.

## Configuration
- `RF_SEQUENCER_SHIFTER_EN` defined:
  - B'=B shifted per the latched `shift`: 00 none, 01 LSL1, 10 LSR1 with zero fill, 11 ASR1.
  - The shift applies to ADD, AND and MVN, never to MOV.
- Not defined: B'=B; `shift` is ignored; no shifter logic is built.

## Test plan
- MOV: reset, then MOV rd=3 imm=8'hF0 -> R3=16'hFFF0 written at E2; `done` pulse; `status`=010.
- ADD: R1=16'h7FFF, R2=16'h0001, ADD rd=0 rn=1 rm=2 -> R0=16'h8000 at E4; `status`={0,1,1}; `busy` high for 4 cycles.
- AND and MVN: R4=16'h00FF, R5=16'h0F0F.
  - AND rd=6 rn=4 rm=5 -> R6=16'h000F.
  - MVN rd=7 rm=5 -> R7=16'hF0F0, written at E3.
- Hazard and back-to-back: R1=16'd5.
  - ADD rd=1 rn=1 rm=1 -> R1=10.
  - `start` asserted in the `done` cycle, and also pulsed mid-op, -> the second instruction is accepted; the mid-op pulse is ignored.
- Reset mid-op: assert `reset` during EXEC of ADD rd=2 -> R2 unchanged, no `done`, `result`=0.
- SHIFTER_EN build: R1=16'h8002, MVN rd=0 rm=1 shift=11 -> R0=~16'hC001=16'h3FFE.
  - Same stimulus without the macro -> R0=16'h7FFD.
